// File: rtl/tilemap_pkg.sv
// tilemap_pkg: shared constants for the tilemap index RAM arbitration path.
package tilemap_pkg;

    localparam int TILEMAP_ADDR_W  = 10;
    localparam int TILEMAP_DATA_W  = 8;
    localparam int TILEMAP_CELLS_X = 22;
    localparam int TILEMAP_CELLS_Y = 17;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE   = 2'd0;
    localparam owner_t OWN_RENDER = 2'd1;
    localparam owner_t OWN_CTL    = 2'd2;
    localparam owner_t OWN_CPU    = 2'd3;

    // Winner vector bit order: [0] render, [1] ctl, [2] cpu.
    localparam int WIN_RENDER = 0;
    localparam int WIN_CTL    = 1;
    localparam int WIN_CPU    = 2;

    // Writes never return data, so they leave no owner behind.
    function automatic owner_t read_owner(input logic [2:0] win, input logic we);
        return we ? OWN_NONE :
               win[WIN_RENDER] ? OWN_RENDER :
               win[WIN_CTL] ? OWN_CTL :
               win[WIN_CPU] ? OWN_CPU : OWN_NONE;
    endfunction

endpackage

// File: rtl/tilemapram_arbiter_if.sv
// tilemapram_arbiter_if: requester handshakes and RAM command bus of the tilemap arbiter.
interface tilemapram_arbiter_if
    import tilemap_pkg::*;
#(
    parameter int ADDR_W = TILEMAP_ADDR_W,
    parameter int DATA_W = TILEMAP_DATA_W
);

    logic              render_req;
    logic [ADDR_W-1:0] render_addr;
    logic              render_gnt;
    logic              render_rvalid;

    logic              ctl_req;
    logic              ctl_we;
    logic [ADDR_W-1:0] ctl_addr;
    logic [DATA_W-1:0] ctl_wdata;
    logic              ctl_gnt;
    logic              ctl_rvalid;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;

    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;

    modport slave (
        input  render_req, render_addr,
        input  ctl_req, ctl_we, ctl_addr, ctl_wdata,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ram_rdata,
        output render_gnt, render_rvalid,
        output ctl_gnt, ctl_rvalid,
        output cpu_gnt, cpu_rvalid,
        output rdata, ram_addr, ram_we, ram_wdata, busy
    );

    modport master (
        output render_req, render_addr,
        output ctl_req, ctl_we, ctl_addr, ctl_wdata,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ram_rdata,
        input  render_gnt, render_rvalid,
        input  ctl_gnt, ctl_rvalid,
        input  cpu_gnt, cpu_rvalid,
        input  rdata, ram_addr, ram_we, ram_wdata, busy
    );

endinterface

// File: rtl/tilemapram_prio_sel.sv
// tilemapram_prio_sel: one-hot winner from render > (starved cpu) > ctl > cpu,
// ignoring any requester still seeing its grant.
module tilemapram_prio_sel
    import tilemap_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic [2:0] req,
    input  logic [2:0] gnt,
    input  logic [3:0] cpu_wait,
    output logic [2:0] win
);

    logic [2:0] elig;
    logic       promote;

    always_comb begin
        elig    = req & ~gnt;
        promote = elig[WIN_CPU] && (cpu_wait == 4'(STARVE_LIMIT));
        win     = elig[WIN_RENDER] ? 3'b001 :
                  promote          ? 3'b100 :
                  elig[WIN_CTL]    ? 3'b010 :
                  elig[WIN_CPU]    ? 3'b100 : 3'b000;
    end

endmodule

// File: rtl/tilemapram_arbiter.sv
// tilemapram_arbiter: shares the single-port tilemap index RAM between renderer, control
// engine and cpu; registers the RAM command and routes read data back to its issuer.
module tilemapram_arbiter
    import tilemap_pkg::*;
#(
    parameter int ADDR_W       = TILEMAP_ADDR_W,
    parameter int DATA_W       = TILEMAP_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input logic                 clk,
    input logic                 reset,
    tilemapram_arbiter_if.slave bus
);

    logic [2:0]        req;
    logic [2:0]        gnt;
    logic [2:0]        win;
    logic [2:0]        rvalid;
    logic [3:0]        cpu_wait;
    owner_t            own_q;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;

    assign req = {bus.cpu_req, bus.ctl_req, bus.render_req};

    tilemapram_prio_sel #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio_sel (
        .req      (req),
        .gnt      (gnt),
        .cpu_wait (cpu_wait),
        .win      (win)
    );

    // With no winner the address and data hold; render only ever reads.
    always_comb begin
        win_addr  = win[WIN_RENDER] ? bus.render_addr :
                    win[WIN_CTL]    ? bus.ctl_addr :
                    win[WIN_CPU]    ? bus.cpu_addr : addr_q;
        win_wdata = win[WIN_CTL] ? bus.ctl_wdata :
                    win[WIN_CPU] ? bus.cpu_wdata : wdata_q;
        win_we    = win[WIN_CTL] ? bus.ctl_we : (win[WIN_CPU] & bus.cpu_we);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt      <= '0;
            rvalid   <= '0;
            own_q    <= OWN_NONE;
            cpu_wait <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            gnt     <= win;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            we_q    <= win_we;
            own_q   <= read_owner(win, win_we);
            rvalid  <= {own_q == OWN_CPU, own_q == OWN_CTL, own_q == OWN_RENDER};
            // The stale req seen alongside the cpu's own grant is not a waiting request.
            cpu_wait <= (!bus.cpu_req || win[WIN_CPU] || gnt[WIN_CPU]) ? 4'd0 :
                        (cpu_wait == 4'(STARVE_LIMIT)) ? cpu_wait : cpu_wait + 4'd1;
        end
    end

    assign bus.render_gnt    = gnt[WIN_RENDER];
    assign bus.ctl_gnt       = gnt[WIN_CTL];
    assign bus.cpu_gnt       = gnt[WIN_CPU];
    assign bus.render_rvalid = rvalid[WIN_RENDER];
    assign bus.ctl_rvalid    = rvalid[WIN_CTL];
    assign bus.cpu_rvalid    = rvalid[WIN_CPU];
    assign bus.ram_addr      = addr_q;
    assign bus.ram_we        = we_q;
    assign bus.ram_wdata     = wdata_q;
    assign bus.rdata         = bus.ram_rdata;
    assign bus.busy          = ~reset & ((|req) | (own_q != OWN_NONE) | (|rvalid));

endmodule
